// File: rtl/t5_pkg.sv
// Shared constants for the t5 load/store unit: opcodes, access sizes,
// FSM encoding and small address helpers.
package t5_pkg;

  localparam logic [4:0] OPC_LOAD  = 5'h00;
  localparam logic [4:0] OPC_STORE = 5'h08;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  // Size field 2'b11 is treated as a word access.
  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
    logic res;
    case (sz)
      SZ_BYTE: res = 1'b0;
      SZ_HALF: res = a[0];
      default: res = (a != 2'b00);
    endcase
    return res;
  endfunction

  function automatic logic [3:0] byte_sel(input logic [1:0] sz, input logic [1:0] a);
    logic [3:0] res;
    case (sz)
      SZ_BYTE: res = 4'b0001 << a;
      SZ_HALF: res = 4'b0011 << {a[1], 1'b0};
      default: res = 4'b1111;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/t5_lsu_align.sv
// Load lane shifter: moves the addressed byte/half down to bit 0 and
// sign- or zero-extends it according to funct3.
module t5_lsu_align
  import t5_pkg::*;
(
  input  logic [31:0] rdat,
  input  logic [1:0]  adr,
  input  logic [2:0]  fn3,
  output logic [31:0] res
);

  logic [31:0] w_sh;
  logic        w_sx;

  // Shift and extend the returned word
  always_comb begin
    w_sh = rdat >> {adr, 3'b000};
    w_sx = 1'b0;
    res  = 32'h0000_0000;
    case (fn3[1:0])
      SZ_BYTE: begin
        w_sx = w_sh[7] & ~fn3[2];
        res  = {{24{w_sx}}, w_sh[7:0]};
      end
      SZ_HALF: begin
        w_sx = w_sh[15] & ~fn3[2];
        res  = {{16{w_sx}}, w_sh[15:0]};
      end
      default: begin
        w_sx = 1'b0;
        res  = w_sh;
      end
    endcase
  end

endmodule

// File: rtl/t5_lsu.sv
// t5 load/store unit: single-outstanding data-bus master with stall,
// bus timeout, aligned load return and misalign/fault reporting.
module t5_lsu
  import t5_pkg::*;
#(
  parameter int TMO = 16,
  parameter int TW  = 5
) (
  input  logic        sclk,
  input  logic        srst,
  input  logic        sena,
  input  logic        xreq,
  input  logic [4:0]  xopc,
  input  logic [2:0]  xfn3,
  input  logic [31:0] xadr,
  input  logic [31:0] xdat,
  output logic [29:0] dwb_adr_o,
  output logic [31:0] dwb_dat_o,
  output logic [3:0]  dwb_sel_o,
  output logic        dwb_we_o,
  output logic        dwb_stb_o,
  output logic        dwb_cyc_o,
  input  logic [31:0] dwb_dat_i,
  input  logic        dwb_ack_i,
  input  logic        dwb_err_i,
  output logic        lstl,
  output logic [31:0] mdat,
  output logic        mval,
  output logic [1:0]  xstb,
  output logic        xwre,
  output logic        lflt
);

  logic [1:0]    r_st;
  logic [TW-1:0] r_cnt;
  logic [29:0]   r_adr;
  logic [31:0]   r_dat;
  logic [3:0]    r_sel;
  logic          r_we;
  logic          r_stb;
  logic          r_cyc;
  logic          r_lstl;
  logic [31:0]   r_mdat;
  logic          r_mval;
  logic [1:0]    r_xstb;
  logic          r_xwre;
  logic          r_lflt;
  logic [2:0]    r_fn3;
  logic [1:0]    r_alo;

  logic          w_ld;
  logic          w_st;
  logic          w_go;
  logic          w_mis;
  logic          w_tmo;
  logic [3:0]    w_sel;
  logic [31:0]   w_ldat;

  assign w_ld  = (xopc == OPC_LOAD);
  assign w_st  = (xopc == OPC_STORE);
  assign w_go  = xreq & sena & (w_ld | w_st);
  assign w_mis = misaligned(xfn3[1:0], xadr[1:0]);
  assign w_sel = byte_sel(xfn3[1:0], xadr[1:0]);
  assign w_tmo = (r_cnt == TW'(TMO - 1));

  t5_lsu_align u_align (
    .rdat (dwb_dat_i),
    .adr  (r_alo),
    .fn3  (r_fn3),
    .res  (w_ldat)
  );

  // Bus FSM, timeout counter and all registered outputs
  always_ff @(posedge sclk or negedge srst) begin
    if (!srst) begin
      r_st   <= ST_IDLE;
      r_cnt  <= '0;
      r_adr  <= 30'h0;
      r_dat  <= 32'h0;
      r_sel  <= 4'h0;
      r_we   <= 1'b0;
      r_stb  <= 1'b0;
      r_cyc  <= 1'b0;
      r_lstl <= 1'b0;
      r_mdat <= 32'h0;
      r_mval <= 1'b0;
      r_xstb <= 2'b00;
      r_xwre <= 1'b0;
      r_lflt <= 1'b0;
      r_fn3  <= 3'h0;
      r_alo  <= 2'h0;
    end else begin
      r_xstb <= 2'b00;
      r_mval <= 1'b0;
      case (r_st)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_go && w_mis) begin
            r_xstb <= 2'b11;
            r_lflt <= 1'b0;
            r_xwre <= w_st;
          end else if (w_go) begin
            r_adr  <= xadr[31:2];
            r_dat  <= xdat;
            r_sel  <= w_sel;
            r_we   <= w_st;
            r_fn3  <= xfn3;
            r_alo  <= xadr[1:0];
            r_cyc  <= 1'b1;
            r_stb  <= 1'b1;
            r_lstl <= 1'b1;
            r_st   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // err has priority over a simultaneous ack
          if (dwb_err_i || (w_tmo && !dwb_ack_i)) begin
            r_cyc  <= 1'b0;
            r_stb  <= 1'b0;
            r_lstl <= 1'b0;
            r_we   <= 1'b0;
            r_xstb <= 2'b11;
            r_lflt <= 1'b1;
            r_xwre <= r_we;
            r_st   <= ST_FLUSH;
          end else if (dwb_ack_i) begin
            r_cyc  <= 1'b0;
            r_stb  <= 1'b0;
            r_lstl <= 1'b0;
            r_we   <= 1'b0;
            if (!r_we) begin
              r_mdat <= w_ldat;
              r_mval <= 1'b1;
            end
            r_st   <= ST_FLUSH;
          end else begin
            r_cnt  <= r_cnt + TW'(1);
          end
        end
        ST_FLUSH: begin
          r_cnt <= '0;
          r_st  <= ST_IDLE;
        end
        default: begin
          r_cyc  <= 1'b0;
          r_stb  <= 1'b0;
          r_lstl <= 1'b0;
          r_cnt  <= '0;
          r_st   <= ST_IDLE;
        end
      endcase
    end
  end

  assign dwb_adr_o = r_adr;
  assign dwb_dat_o = r_dat;
  assign dwb_sel_o = r_sel;
  assign dwb_we_o  = r_we;
  assign dwb_stb_o = r_stb;
  assign dwb_cyc_o = r_cyc;
  assign lstl      = r_lstl;
  assign mdat      = r_mdat;
  assign mval      = r_mval;
  assign xstb      = r_xstb;
  assign xwre      = r_xwre;
  assign lflt      = r_lflt;

endmodule

// File: tb/tb_t5_lsu.sv
// Directed bench for t5_lsu: loads, stores, misalign, timeout, bus error
// and asynchronous reset during a bus cycle.
module tb_t5_lsu;

  logic        sclk = 1'b0;
  logic        srst;
  logic        sena;
  logic        xreq;
  logic [4:0]  xopc;
  logic [2:0]  xfn3;
  logic [31:0] xadr;
  logic [31:0] xdat;
  logic [29:0] dwb_adr_o;
  logic [31:0] dwb_dat_o;
  logic [3:0]  dwb_sel_o;
  logic        dwb_we_o;
  logic        dwb_stb_o;
  logic        dwb_cyc_o;
  logic [31:0] dwb_dat_i;
  logic        dwb_ack_i;
  logic        dwb_err_i;
  logic        lstl;
  logic [31:0] mdat;
  logic        mval;
  logic [1:0]  xstb;
  logic        xwre;
  logic        lflt;

  int n_pass = 0;
  int n_tot  = 0;

  t5_lsu #(.TMO(16), .TW(5)) dut (
    .sclk      (sclk),
    .srst      (srst),
    .sena      (sena),
    .xreq      (xreq),
    .xopc      (xopc),
    .xfn3      (xfn3),
    .xadr      (xadr),
    .xdat      (xdat),
    .dwb_adr_o (dwb_adr_o),
    .dwb_dat_o (dwb_dat_o),
    .dwb_sel_o (dwb_sel_o),
    .dwb_we_o  (dwb_we_o),
    .dwb_stb_o (dwb_stb_o),
    .dwb_cyc_o (dwb_cyc_o),
    .dwb_dat_i (dwb_dat_i),
    .dwb_ack_i (dwb_ack_i),
    .dwb_err_i (dwb_err_i),
    .lstl      (lstl),
    .mdat      (mdat),
    .mval      (mval),
    .xstb      (xstb),
    .xwre      (xwre),
    .lflt      (lflt)
  );

  always #5 sclk = ~sclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic nclk();
    @(negedge sclk);
  endtask

  task automatic req(input logic [4:0] opc, input logic [2:0] fn3,
                     input logic [31:0] adr, input logic [31:0] dat);
    xreq = 1'b1;
    xopc = opc;
    xfn3 = fn3;
    xadr = adr;
    xdat = dat;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    srst = 1'b0; sena = 1'b1; xreq = 1'b0; xopc = 5'h00; xfn3 = 3'h0;
    xadr = 32'h0; xdat = 32'h0; dwb_dat_i = 32'h0; dwb_ack_i = 1'b0; dwb_err_i = 1'b0;
    nclk(); nclk();
    chk("rst_cyc",  {31'h0, dwb_cyc_o}, 32'h0);
    chk("rst_stb",  {31'h0, dwb_stb_o}, 32'h0);
    chk("rst_lstl", {31'h0, lstl}, 32'h0);
    chk("rst_mdat", mdat, 32'h0);
    chk("rst_mval", {31'h0, mval}, 32'h0);
    chk("rst_xstb", {30'h0, xstb}, 32'h0);
    srst = 1'b1;

    // LB at 0x1003, one wait state
    nclk();
    req(5'h00, 3'b000, 32'h0000_1003, 32'h0);
    nclk();
    xreq = 1'b0;
    chk("lb_cyc",  {31'h0, dwb_cyc_o}, 32'h1);
    chk("lb_stb",  {31'h0, dwb_stb_o}, 32'h1);
    chk("lb_sel",  {28'h0, dwb_sel_o}, 32'h8);
    chk("lb_adr",  {2'b00, dwb_adr_o}, 32'h0000_0400);
    chk("lb_we",   {31'h0, dwb_we_o}, 32'h0);
    chk("lb_lstl1", {31'h0, lstl}, 32'h1);
    nclk();
    chk("lb_lstl2", {31'h0, lstl}, 32'h1);
    dwb_ack_i = 1'b1; dwb_dat_i = 32'h80AA_5511;
    nclk();
    dwb_ack_i = 1'b0;
    chk("lb_mval", {31'h0, mval}, 32'h1);
    chk("lb_mdat", mdat, 32'hFFFF_FF80);
    chk("lb_cyc_drop", {31'h0, dwb_cyc_o}, 32'h0);
    chk("lb_lstl_drop", {31'h0, lstl}, 32'h0);
    nclk();
    chk("lb_mval_pulse", {31'h0, mval}, 32'h0);
    chk("lb_mdat_hold", mdat, 32'hFFFF_FF80);

    // LHU at 0x2002, immediate ack
    req(5'h00, 3'b101, 32'h0000_2002, 32'h0);
    nclk();
    xreq = 1'b0;
    chk("lhu_sel", {28'h0, dwb_sel_o}, 32'hC);
    dwb_ack_i = 1'b1; dwb_dat_i = 32'h9ABC_1234;
    nclk();
    dwb_ack_i = 1'b0;
    chk("lhu_mval", {31'h0, mval}, 32'h1);
    chk("lhu_mdat", mdat, 32'h0000_9ABC);
    nclk();

    // SW at 0x3000, immediate ack
    req(5'h08, 3'b010, 32'h0000_3000, 32'hDEAD_BEEF);
    nclk();
    xreq = 1'b0;
    chk("sw_we",  {31'h0, dwb_we_o}, 32'h1);
    chk("sw_sel", {28'h0, dwb_sel_o}, 32'hF);
    chk("sw_adr", {2'b00, dwb_adr_o}, 32'h0000_0C00);
    chk("sw_dat", dwb_dat_o, 32'hDEAD_BEEF);
    dwb_ack_i = 1'b1;
    nclk();
    dwb_ack_i = 1'b0;
    chk("sw_mval", {31'h0, mval}, 32'h0);
    chk("sw_mdat_hold", mdat, 32'h0000_9ABC);
    chk("sw_xstb", {30'h0, xstb}, 32'h0);
    nclk();

    // Misaligned SH then misaligned LW back to back
    req(5'h08, 3'b001, 32'h0000_4001, 32'h1234_5678);
    nclk();
    chk("sh_mis_cyc",  {31'h0, dwb_cyc_o}, 32'h0);
    chk("sh_mis_xstb", {30'h0, xstb}, 32'h3);
    chk("sh_mis_xwre", {31'h0, xwre}, 32'h1);
    chk("sh_mis_lflt", {31'h0, lflt}, 32'h0);
    req(5'h00, 3'b010, 32'h0000_4002, 32'h0);
    nclk();
    xreq = 1'b0;
    chk("lw_mis_cyc",  {31'h0, dwb_cyc_o}, 32'h0);
    chk("lw_mis_xstb", {30'h0, xstb}, 32'h3);
    chk("lw_mis_xwre", {31'h0, xwre}, 32'h0);
    chk("lw_mis_lflt", {31'h0, lflt}, 32'h0);
    nclk();
    chk("mis_xstb_pulse", {30'h0, xstb}, 32'h0);

    // LW with no ack: strobe held exactly 16 cycles, then fault
    req(5'h00, 3'b010, 32'h0000_5000, 32'h0);
    nclk();
    xreq = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("tmo_stb_%0d", i), {31'h0, dwb_stb_o}, 32'h1);
      nclk();
    end
    chk("tmo_stb_drop", {31'h0, dwb_stb_o}, 32'h0);
    chk("tmo_xstb", {30'h0, xstb}, 32'h3);
    chk("tmo_lflt", {31'h0, lflt}, 32'h1);
    chk("tmo_xwre", {31'h0, xwre}, 32'h0);
    chk("tmo_mval", {31'h0, mval}, 32'h0);
    nclk();
    chk("tmo_flush_lstl", {31'h0, lstl}, 32'h0);
    chk("tmo_flush_xstb", {30'h0, xstb}, 32'h0);
    nclk();

    // LW with err and ack together: err wins
    req(5'h00, 3'b010, 32'h0000_5004, 32'h0);
    nclk();
    xreq = 1'b0;
    dwb_ack_i = 1'b1; dwb_err_i = 1'b1; dwb_dat_i = 32'h1234_5678;
    nclk();
    dwb_ack_i = 1'b0; dwb_err_i = 1'b0;
    chk("err_xstb", {30'h0, xstb}, 32'h3);
    chk("err_lflt", {31'h0, lflt}, 32'h1);
    chk("err_mval", {31'h0, mval}, 32'h0);
    chk("err_mdat", mdat, 32'h0000_9ABC);
    chk("err_cyc",  {31'h0, dwb_cyc_o}, 32'h0);
    nclk();
    nclk();

    // Asynchronous reset while BUSY
    req(5'h00, 3'b010, 32'h0000_6000, 32'h0);
    nclk();
    xreq = 1'b0;
    chk("ar_cyc_busy", {31'h0, dwb_cyc_o}, 32'h1);
    #2 srst = 1'b0;
    #1;
    chk("ar_cyc",  {31'h0, dwb_cyc_o}, 32'h0);
    chk("ar_stb",  {31'h0, dwb_stb_o}, 32'h0);
    chk("ar_lstl", {31'h0, lstl}, 32'h0);
    nclk();
    chk("ar_xstb", {30'h0, xstb}, 32'h0);
    srst = 1'b1;
    req(5'h00, 3'b010, 32'h0000_6004, 32'h0);
    nclk();
    xreq = 1'b0;
    chk("ar_lw_cyc", {31'h0, dwb_cyc_o}, 32'h1);
    chk("ar_lw_adr", {2'b00, dwb_adr_o}, 32'h0000_1801);
    dwb_ack_i = 1'b1; dwb_dat_i = 32'hCAFE_F00D;
    nclk();
    dwb_ack_i = 1'b0;
    chk("ar_lw_mval", {31'h0, mval}, 32'h1);
    chk("ar_lw_mdat", mdat, 32'hCAFE_F00D);
    chk("ar_lw_xstb", {30'h0, xstb}, 32'h0);
    nclk();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
